// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time controller for a square-wave clock divider.
// Divisor changes land on half-period boundaries; clk_out always parks low.
module clk_div_ctrl #(
  parameter int CNT_W   = 32,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PEND,
    S_STOP
  } state_t;

  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_div_act;
  logic [CNT_W-1:0] r_div_pend;
  logic             r_has_pend;
  logic             r_clk_out;
  logic             r_tick;
  logic             r_cfg_err;

  logic             w_active;
  logic             w_bound;
  logic             w_xfer;
  logic             w_xfer_ok;
  logic             w_park;
  logic [CNT_W-1:0] w_last;

  assign w_active  = (r_state != S_IDLE);
  assign w_last    = r_div_act - ONE;
  assign w_bound   = w_active && (r_count == w_last);
  assign cfg_ready = (r_state != S_PEND);
  assign w_xfer    = cfg_valid & cfg_ready;
  assign w_xfer_ok = w_xfer & (cfg_div != '0);
  // Stop completes once clk_out is low or is about to fall.
  assign w_park    = !en && (!r_clk_out || w_bound);

  assign cfg_err = r_cfg_err;
  assign clk_out = r_clk_out;
  assign tick    = r_tick;
  assign busy    = w_active;

  // Single FSM: counter, divisor registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_div_act  <= DEF;
      r_div_pend <= '0;
      r_has_pend <= 1'b0;
      r_clk_out  <= 1'b0;
      r_tick     <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= w_xfer && (cfg_div == '0);
      r_tick    <= 1'b0;
      if (!w_active) begin
        r_count <= '0;
      end else if (w_bound) begin
        r_count   <= '0;
        r_clk_out <= ~r_clk_out;
        r_tick    <= 1'b1;
      end else begin
        r_count <= r_count + ONE;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_xfer_ok) begin
            r_div_act <= cfg_div;
          end
          if (en) begin
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          if (w_xfer_ok) begin
            r_div_pend <= cfg_div;
            r_has_pend <= 1'b1;
          end
          if (!en) begin
            r_state <= S_STOP;
          end else if (w_xfer_ok) begin
            r_state <= S_PEND;
          end
        end

        S_PEND: begin
          if (w_bound) begin
            r_div_act  <= r_div_pend;
            r_has_pend <= 1'b0;
            r_state    <= en ? S_RUN : S_STOP;
          end else if (!en) begin
            r_state <= S_STOP;
          end
        end

        S_STOP: begin
          if (w_park) begin
            // Clock is parked: any divisor waiting can land now.
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_clk_out  <= 1'b0;
            r_tick     <= r_clk_out;
            r_has_pend <= 1'b0;
            if (w_xfer_ok) begin
              r_div_act <= cfg_div;
            end else if (r_has_pend) begin
              r_div_act <= r_div_pend;
            end
          end else begin
            if (w_bound && r_has_pend) begin
              r_div_act <= r_div_pend;
            end
            if (w_xfer_ok) begin
              r_div_pend <= cfg_div;
              r_has_pend <= 1'b1;
            end else if (w_bound) begin
              r_has_pend <= 1'b0;
            end
            if (en) begin
              if (w_xfer_ok || (r_has_pend && !w_bound)) begin
                r_state <= S_PEND;
              end else begin
                r_state <= S_RUN;
              end
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed scoreboard bench for clk_div_ctrl.
// Observed vector order: {clk_out, tick, busy, cfg_ready, cfg_err}.
module tb_clk_div_ctrl;

  localparam int CNT_W = 32;

  logic             clk;
  logic             reset;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             tick;
  logic             busy;

  clk_div_ctrl #(
    .CNT_W  (CNT_W),
    .DEF_DIV(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .clk_out  (clk_out),
    .tick     (tick),
    .busy     (busy)
  );

  typedef struct {
    int         cyc;
    string      tag;
    logic [4:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   total;
  int   bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void push(int c, string t, logic [4:0] v);
    exp_t e;
    e.cyc = c;
    e.tag = t;
    e.v   = v;
    sb.push_back(e);
  endfunction

  task automatic go_to(int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Pop and compare every expectation due this cycle.
  always @(negedge clk) begin
    logic [4:0] obs;
    obs = {clk_out, tick, busy, cfg_ready, cfg_err};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        total++;
        assert (obs === sb[i].v) else begin
          bad++;
          $error("FAIL %s obs=%b exp=%b", sb[i].tag, obs, sb[i].v);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    int b;
    int c0;
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    @(negedge clk);
    @(negedge clk);
    b = cyc;
    push(b + 1, "rst", 5'b00010);
    go_to(b + 1);

    // Default divisor run
    c0    = cyc;
    reset = 1'b0;
    en    = 1'b1;
    push(c0 + 1,  "run_entry", 5'b00110);
    push(c0 + 4,  "pre_tog",   5'b00110);
    push(c0 + 5,  "tog1",      5'b11110);
    push(c0 + 6,  "hold1",     5'b10110);
    push(c0 + 9,  "tog2",      5'b01110);
    push(c0 + 13, "tog3",      5'b11110);

    // Change to 2 at count=1
    go_to(c0 + 14);
    cfg_valid = 1'b1;
    cfg_div   = 2;
    push(c0 + 15, "pend",   5'b10100);
    push(c0 + 16, "pend2",  5'b10100);
    push(c0 + 17, "newdiv", 5'b01110);
    push(c0 + 19, "d2a",    5'b11110);
    push(c0 + 20, "d2b",    5'b10110);
    push(c0 + 21, "d2c",    5'b01110);
    go_to(c0 + 15);
    cfg_valid = 1'b0;

    // Zero divisor rejected, coincident with a boundary
    go_to(c0 + 22);
    cfg_valid = 1'b1;
    cfg_div   = 0;
    push(c0 + 23, "zero_err",  5'b11111);
    push(c0 + 24, "err_clr",   5'b10110);
    push(c0 + 25, "zero_keep", 5'b01110);
    go_to(c0 + 23);
    cfg_valid = 1'b0;

    // Transfer on a boundary cycle: old divisor finishes one more half
    go_to(c0 + 26);
    cfg_valid = 1'b1;
    cfg_div   = 4;
    push(c0 + 27, "xfer_at_b", 5'b11100);
    push(c0 + 28, "pend_old",  5'b10100);
    push(c0 + 29, "apply4",    5'b01110);
    push(c0 + 32, "d4a",       5'b00110);
    push(c0 + 33, "d4b",       5'b11110);
    go_to(c0 + 27);
    cfg_valid = 1'b0;

    // Stop with clk_out high at count=1
    go_to(c0 + 42);
    en = 1'b0;
    push(c0 + 43, "stop_hi",  5'b10110);
    push(c0 + 44, "stop_hi2", 5'b10110);
    push(c0 + 45, "park",     5'b01010);
    push(c0 + 46, "idle",     5'b00010);

    // Restart, then stop with clk_out low
    go_to(c0 + 46);
    en = 1'b1;
    push(c0 + 47, "rerun",      5'b00110);
    push(c0 + 51, "rerun_tog",  5'b11110);
    push(c0 + 55, "rerun_tog2", 5'b01110);
    go_to(c0 + 56);
    en = 1'b0;
    push(c0 + 57, "stop_lo", 5'b00110);
    push(c0 + 58, "idle_lo", 5'b00010);

    // Divisor 1 loaded in IDLE together with en
    go_to(c0 + 58);
    cfg_valid = 1'b1;
    cfg_div   = 1;
    en        = 1'b1;
    push(c0 + 59, "div1_run", 5'b00110);
    push(c0 + 60, "div1_t1",  5'b11110);
    push(c0 + 61, "div1_t2",  5'b01110);
    push(c0 + 62, "div1_t3",  5'b11110);
    push(c0 + 63, "div1_t4",  5'b01110);
    go_to(c0 + 59);
    cfg_valid = 1'b0;
    go_to(c0 + 63);
    en = 1'b0;
    push(c0 + 64, "div1_stop", 5'b11110);
    push(c0 + 65, "div1_park", 5'b01010);
    push(c0 + 66, "div1_idle", 5'b00010);

    // Reset while a divisor of 7 is pending
    go_to(c0 + 66);
    en = 1'b1;
    push(c0 + 67, "r6_run", 5'b00110);
    go_to(c0 + 67);
    cfg_valid = 1'b1;
    cfg_div   = 7;
    push(c0 + 68, "r6_pend", 5'b11100);
    go_to(c0 + 68);
    cfg_valid = 1'b0;
    reset     = 1'b1;
    push(c0 + 69, "r6_reset", 5'b00010);
    go_to(c0 + 69);
    reset = 1'b0;
    push(c0 + 70, "def_run",  5'b00110);
    push(c0 + 73, "def_pre",  5'b00110);
    push(c0 + 74, "def_tog",  5'b11110);
    push(c0 + 77, "not7",     5'b10110);
    push(c0 + 78, "def_tog2", 5'b01110);

    go_to(c0 + 80);
    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_drain left=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
